// File: rtl/mfp_ahb_sdram_arbiter.sv
// rtl/mfp_ahb_sdram_arbiter.sv - two-master AHB-Lite arbiter in front of the SDRAM controller slave
// Optional macro MFP_SDRAM_ARB_PRIO_EN: M0 fixed priority with M1 starvation limit (else round-robin).
module mfp_ahb_sdram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        M0_HSEL,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,
  input  logic        M1_HSEL,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,
  output logic        S_HSEL,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  output logic        S_HREADY,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HREADYOUT,
  input  logic        S_HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       dval_q, dval_d;
  logic [1:0]       hready_q, hready_d;
  logic [1:0][31:0] addr_q, addr_d;
  logic [1:0][31:0] wdata_q, wdata_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic [1:0]       write_q, write_d;
  logic [1:0][2:0]  size_q, size_d;
  logic             s_hsel_q, s_hsel_d;
  logic [1:0]       s_htrans_q, s_htrans_d;
  logic [31:0]      s_haddr_q, s_haddr_d;
  logic             s_hwrite_q, s_hwrite_d;
  logic [2:0]       s_hsize_q, s_hsize_d;
  logic [31:0]      s_hwdata_q, s_hwdata_d;

  logic [1:0]       m_req;
  logic [1:0][31:0] m_haddr, m_hwdata;
  logic [1:0]       m_hwrite;
  logic [1:0][2:0]  m_hsize;
  logic             pick;
  logic             unused_sig;

  assign m_haddr    = {M1_HADDR, M0_HADDR};
  assign m_hwdata   = {M1_HWDATA, M0_HWDATA};
  assign m_hwrite   = {M1_HWRITE, M0_HWRITE};
  assign m_hsize    = {M1_HSIZE, M0_HSIZE};
  assign m_req      = {M1_HSEL & M1_HTRANS[1], M0_HSEL & M0_HTRANS[1]} & hready_q;
  assign unused_sig = ^{S_HRESP, M0_HTRANS[0], M1_HTRANS[0]};

`ifdef MFP_SDRAM_ARB_PRIO_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    pick = pend_q[1] & (~pend_q[0] | (cnt_q == CNT_W'(STARVE_LIMIT)));
  end
`else
  localparam int unused_starve = STARVE_LIMIT;

  always_comb begin
    pick = (pend_q == 2'b11) ? ~last_q : pend_q[1];
  end
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    pend_d     = pend_q;
    dval_d     = dval_q;
    hready_d   = hready_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    write_d    = write_q;
    size_d     = size_q;
    s_hsel_d   = s_hsel_q;
    s_htrans_d = s_htrans_q;
    s_haddr_d  = s_haddr_q;
    s_hwrite_d = s_hwrite_q;
    s_hsize_d  = s_hsize_q;
    s_hwdata_d = s_hwdata_q;
`ifdef MFP_SDRAM_ARB_PRIO_EN
    cnt_d      = cnt_q;
    if (!pend_q[1]) cnt_d = '0;
`endif

    // Write data follows the accepted address by one cycle; it lands before WAIT can use it.
    for (int m = 0; m < 2; m++) begin
      if (pend_q[m] && !dval_q[m]) begin
        wdata_d[m] = m_hwdata[m];
        dval_d[m]  = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          gnt_d      = pick;
          last_d     = pick;
          state_d    = ST_ISSUE;
          s_hsel_d   = 1'b1;
          s_htrans_d = HTRANS_NONSEQ;
          s_haddr_d  = addr_q[pick];
          s_hwrite_d = write_q[pick];
          s_hsize_d  = size_q[pick];
`ifdef MFP_SDRAM_ARB_PRIO_EN
          if (pick)           cnt_d = '0;
          else if (pend_q[1]) cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      ST_ISSUE: begin
        if (S_HREADYOUT) begin
          state_d    = ST_WAIT;
          s_hsel_d   = 1'b0;
          s_htrans_d = HTRANS_IDLE;
          s_hwdata_d = wdata_q[gnt_q];
        end
      end
      ST_WAIT: begin
        if (S_HREADYOUT) begin
          rdata_d[gnt_q]  = S_HRDATA;
          hready_d[gnt_q] = 1'b1;
          state_d         = ST_DONE;
        end
      end
      ST_DONE: begin
        pend_d[gnt_q] = 1'b0;
        dval_d[gnt_q] = 1'b0;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new address phase in the DONE cycle overrides the completion clear.
    for (int m = 0; m < 2; m++) begin
      if (m_req[m]) begin
        addr_d[m]   = m_haddr[m];
        write_d[m]  = m_hwrite[m];
        size_d[m]   = m_hsize[m];
        pend_d[m]   = 1'b1;
        dval_d[m]   = 1'b0;
        hready_d[m] = 1'b0;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      pend_q     <= '0;
      dval_q     <= '0;
      hready_q   <= 2'b11;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      write_q    <= '0;
      size_q     <= '0;
      s_hsel_q   <= 1'b0;
      s_htrans_q <= HTRANS_IDLE;
      s_haddr_q  <= '0;
      s_hwrite_q <= 1'b0;
      s_hsize_q  <= '0;
      s_hwdata_q <= '0;
`ifdef MFP_SDRAM_ARB_PRIO_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      dval_q     <= dval_d;
      hready_q   <= hready_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      write_q    <= write_d;
      size_q     <= size_d;
      s_hsel_q   <= s_hsel_d;
      s_htrans_q <= s_htrans_d;
      s_haddr_q  <= s_haddr_d;
      s_hwrite_q <= s_hwrite_d;
      s_hsize_q  <= s_hsize_d;
      s_hwdata_q <= s_hwdata_d;
`ifdef MFP_SDRAM_ARB_PRIO_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign M0_HREADY = hready_q[0];
  assign M1_HREADY = hready_q[1];
  assign M0_HRDATA = rdata_q[0];
  assign M1_HRDATA = rdata_q[1];
  assign M0_HRESP  = 1'b0;
  assign M1_HRESP  = 1'b0;
  assign S_HSEL    = s_hsel_q;
  assign S_HTRANS  = s_htrans_q;
  assign S_HADDR   = s_haddr_q;
  assign S_HWRITE  = s_hwrite_q;
  assign S_HSIZE   = s_hsize_q;
  assign S_HWDATA  = s_hwdata_q;
  assign S_HREADY  = S_HREADYOUT;

endmodule

// File: tb/tb_mfp_ahb_sdram_arbiter.sv
// tb/tb_mfp_ahb_sdram_arbiter.sv - directed scoreboard bench for mfp_ahb_sdram_arbiter
module tb_mfp_ahb_sdram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       m_hsel, m_hwrite;
  logic [1:0][1:0]  m_htrans;
  logic [1:0][31:0] m_haddr, m_hwdata;
  logic [1:0][2:0]  m_hsize;
  logic [31:0]      m0_hrdata, m1_hrdata;
  logic             m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic             s_hsel, s_hwrite, s_hready;
  logic [1:0]       s_htrans;
  logic [31:0]      s_haddr, s_hwdata;
  logic [2:0]       s_hsize;
  logic             s_hreadyout;
  logic [31:0]      s_hrdata;

  int errors = 0;
  int checks = 0;

  logic        busy = 1'b0;
  int          ws = 0;
  logic        dphase = 1'b0;
  int          wcnt = 0;
  logic [31:0] lat_addr = '0;
  logic        lat_wr = 1'b0;
  logic [2:0]  lat_size = '0;
  logic        a_acc = 1'b0, d_done = 1'b0;
  logic [31:0] smp_addr = '0, smp_wdata = '0;
  logic        smp_wr = 1'b0;
  logic [2:0]  smp_size = '0;

  typedef struct packed {logic [31:0] addr; logic wr; logic [2:0] size; logic [31:0] wdata;} s_txn_t;
  typedef struct packed {logic wr; logic [31:0] d;} m_txn_t;
  s_txn_t s_exp[$];
  m_txn_t m_exp0[$], m_exp1[$];
  s_txn_t st;
  m_txn_t mt;

`ifdef MFP_SDRAM_ARB_PRIO_EN
  localparam int N0 = 5;
  localparam int N1 = 2;
`else
  localparam int N0 = 3;
  localparam int N1 = 3;
`endif

  function automatic logic [31:0] fdata(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hCAFE_F00D;
    return (a * 32'h0001_0003) ^ 32'h5A5A_0000;
  endfunction

  assign s_hreadyout = !busy && !(dphase && wcnt != 0);
  assign s_hrdata    = dphase ? fdata(lat_addr) : 32'h0;

  mfp_ahb_sdram_arbiter #(.STARVE_LIMIT(4)) dut (
    .HCLK(clk), .HRESET(rst),
    .M0_HSEL(m_hsel[0]), .M0_HADDR(m_haddr[0]), .M0_HTRANS(m_htrans[0]), .M0_HWRITE(m_hwrite[0]),
    .M0_HSIZE(m_hsize[0]), .M0_HWDATA(m_hwdata[0]), .M0_HRDATA(m0_hrdata), .M0_HREADY(m0_hready),
    .M0_HRESP(m0_hresp),
    .M1_HSEL(m_hsel[1]), .M1_HADDR(m_haddr[1]), .M1_HTRANS(m_htrans[1]), .M1_HWRITE(m_hwrite[1]),
    .M1_HSIZE(m_hsize[1]), .M1_HWDATA(m_hwdata[1]), .M1_HRDATA(m1_hrdata), .M1_HREADY(m1_hready),
    .M1_HRESP(m1_hresp),
    .S_HSEL(s_hsel), .S_HADDR(s_haddr), .S_HTRANS(s_htrans), .S_HWRITE(s_hwrite), .S_HSIZE(s_hsize),
    .S_HWDATA(s_hwdata), .S_HREADY(s_hready), .S_HRDATA(s_hrdata), .S_HREADYOUT(s_hreadyout),
    .S_HRESP(1'b0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: samples the bus on the falling edge, updates on the rising edge.
  always @(negedge clk) begin
    a_acc     = s_hsel && s_htrans[1] && s_hreadyout;
    d_done    = dphase && s_hreadyout;
    smp_addr  = s_haddr;
    smp_wr    = s_hwrite;
    smp_size  = s_hsize;
    smp_wdata = s_hwdata;
    if (!rst && dphase && s_exp.size() > 0 && s_exp[0].wr)
      chk("wait_hwdata", 64'(s_hwdata), 64'(s_exp[0].wdata));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dphase <= 1'b0;
      wcnt   <= 0;
    end else begin
      if (d_done) begin
        if (s_exp.size() == 0) chk("slave_unexpected", 64'(1), 64'(0));
        else begin
          st = s_exp.pop_front();
          chk("slave_ctrl", 64'({lat_addr, lat_wr, lat_size}), 64'({st.addr, st.wr, st.size}));
          if (st.wr) chk("slave_wdata", 64'(smp_wdata), 64'(st.wdata));
        end
        dphase <= 1'b0;
      end
      if (a_acc) begin
        dphase   <= 1'b1;
        wcnt     <= ws;
        lat_addr <= smp_addr;
        lat_wr   <= smp_wr;
        lat_size <= smp_size;
      end else if (dphase && wcnt > 0) begin
        wcnt <= wcnt - 1;
      end
    end
  end

  logic prev0 = 1'b1, prev1 = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      prev0 = 1'b1;
      prev1 = 1'b1;
    end else begin
      if (!prev0 && m0_hready) begin
        if (m_exp0.size() == 0) chk("m0_unexpected", 64'(1), 64'(0));
        else begin
          mt = m_exp0.pop_front();
          if (!mt.wr) chk("m0_hrdata", 64'(m0_hrdata), 64'(mt.d));
        end
      end
      if (!prev1 && m1_hready) begin
        if (m_exp1.size() == 0) chk("m1_unexpected", 64'(1), 64'(0));
        else begin
          mt = m_exp1.pop_front();
          if (!mt.wr) chk("m1_hrdata", 64'(m1_hrdata), 64'(mt.d));
        end
      end
      prev0 = m0_hready;
      prev1 = m1_hready;
    end
  end

  task automatic wait_ready(input int m);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_hready : m1_hready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ready_timeout", 64'(ok), 64'(1));
  endtask

  task automatic master_seq(input int m, input int n, input logic [31:0] base, input logic wr,
                            input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] a;
    a = base;
    m_hsel[m] = 1'b1; m_htrans[m] = 2'b10; m_haddr[m] = a; m_hwrite[m] = wr; m_hsize[m] = sz;
    for (int i = 0; i < n; i++) begin
      wait_ready(m);
      @(posedge clk); #1;
      if (m == 0) m_exp0.push_back('{wr: wr, d: fdata(a)});
      else        m_exp1.push_back('{wr: wr, d: fdata(a)});
      m_hwdata[m] = wd + 32'(i);
      a = a + 32'd4;
      if (i < n - 1) m_haddr[m] = a;
      else begin
        m_hsel[m] = 1'b0; m_htrans[m] = 2'b00;
      end
    end
    wait_ready(m);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_s_ctrl"}, 64'({s_hsel, s_htrans, s_hwrite, s_hsize}), 64'(0));
    chk({tag, "_s_haddr"}, 64'(s_haddr), 64'(0));
    chk({tag, "_s_hwdata"}, 64'(s_hwdata), 64'(0));
    chk({tag, "_m_hready"}, 64'({m0_hready, m1_hready}), 64'(2'b11));
    chk({tag, "_m0_hrdata"}, 64'(m0_hrdata), 64'(0));
    chk({tag, "_m1_hrdata"}, 64'(m1_hrdata), 64'(0));
    chk({tag, "_m_hresp"}, 64'({m0_hresp, m1_hresp}), 64'(0));
    chk({tag, "_s_hready"}, 64'(s_hready), 64'(s_hreadyout));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1;
    m_hsel = '0; m_htrans = '0; m_haddr = '0; m_hwdata = '0; m_hwrite = '0; m_hsize = '0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // M0 read with two wait states: cycle-exact latency
    ws = 2;
    @(posedge clk); #1;
    m_hsel[0] = 1'b1; m_htrans[0] = 2'b10; m_haddr[0] = 32'h0000_0100; m_hwrite[0] = 1'b0; m_hsize[0] = 3'd2;
    m_exp0.push_back('{wr: 1'b0, d: 32'hCAFE_F00D});
    s_exp.push_back('{addr: 32'h0000_0100, wr: 1'b0, size: 3'd2, wdata: 32'h0});
    @(posedge clk); #1;
    m_hsel[0] = 1'b0; m_htrans[0] = 2'b00;
    @(negedge clk); chk("c1_m0_hready", 64'(m0_hready), 64'(0));
    @(negedge clk); chk("c2_s_htrans", 64'({s_hsel, s_htrans}), 64'(3'b110));
    chk("c2_s_haddr", 64'(s_haddr), 64'(32'h100));
    @(negedge clk); chk("c3_s_htrans", 64'({s_hsel, s_htrans}), 64'(3'b000));
    repeat (2) @(negedge clk);
    chk("c5_m0_hready", 64'(m0_hready), 64'(0));
    @(negedge clk);
    chk("c6_m0_hready", 64'(m0_hready), 64'(1));
    chk("c6_m0_hrdata", 64'(m0_hrdata), 64'(32'hCAFE_F00D));
    chk("c6_m1_hready", 64'(m1_hready), 64'(1));
    @(posedge clk); #1;

    // M1 byte write
    ws = 1;
    s_exp.push_back('{addr: 32'h0000_0003, wr: 1'b1, size: 3'd0, wdata: 32'h0000_005A});
    master_seq(1, 1, 32'h0000_0003, 1'b1, 3'd0, 32'h0000_005A);
    @(posedge clk); #1;
    chk("hold_s_hwdata", 64'(s_hwdata), 64'(32'h5A));
    chk("hold_s_ctrl", 64'({s_haddr, s_hwrite, s_hsize}), 64'({32'h3, 1'b1, 3'd0}));

    // Both masters saturating from the same cycle
`ifdef MFP_SDRAM_ARB_PRIO_EN
    for (int i = 0; i < 4; i++) s_exp.push_back('{addr: 32'h1000 + 32'(4 * i), wr: 1'b0, size: 3'd2, wdata: 32'h0});
    s_exp.push_back('{addr: 32'h2000, wr: 1'b0, size: 3'd2, wdata: 32'h0});
    s_exp.push_back('{addr: 32'h1010, wr: 1'b0, size: 3'd2, wdata: 32'h0});
    s_exp.push_back('{addr: 32'h2004, wr: 1'b0, size: 3'd2, wdata: 32'h0});
`else
    for (int i = 0; i < 3; i++) begin
      s_exp.push_back('{addr: 32'h1000 + 32'(4 * i), wr: 1'b0, size: 3'd2, wdata: 32'h0});
      s_exp.push_back('{addr: 32'h2000 + 32'(4 * i), wr: 1'b0, size: 3'd2, wdata: 32'h0});
    end
`endif
    fork
      master_seq(0, N0, 32'h1000, 1'b0, 3'd2, 32'h0);
      master_seq(1, N1, 32'h2000, 1'b0, 3'd2, 32'h0);
    join
    @(posedge clk); #1;
    chk("alt_drain", 64'(s_exp.size()), 64'(0));

    // Slave busy while ISSUE holds M0; M1 waits behind it
    ws = 0;
    busy = 1'b1;
    s_exp.push_back('{addr: 32'h0000_0200, wr: 1'b0, size: 3'd2, wdata: 32'h0});
    s_exp.push_back('{addr: 32'h0000_3000, wr: 1'b0, size: 3'd2, wdata: 32'h0});
    fork
      master_seq(0, 1, 32'h0000_0200, 1'b0, 3'd2, 32'h0);
      master_seq(1, 1, 32'h0000_3000, 1'b0, 3'd2, 32'h0);
      begin
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
          @(negedge clk);
          if (s_htrans == 2'b10) found = 1'b1;
        end
        chk("busy_issue_seen", 64'(found), 64'(1));
        repeat (10) begin
          @(negedge clk);
          chk("busy_s_htrans", 64'({s_hsel, s_htrans}), 64'(3'b110));
          chk("busy_s_haddr", 64'(s_haddr), 64'(32'h200));
        end
        busy = 1'b0;
      end
    join
    @(posedge clk); #1;
    chk("busy_drain", 64'(s_exp.size()), 64'(0));

    // Reset pulsed during WAIT
    ws = 3;
    m_hsel[0] = 1'b1; m_htrans[0] = 2'b10; m_haddr[0] = 32'h0000_0300; m_hwrite[0] = 1'b0; m_hsize[0] = 3'd2;
    s_exp.push_back('{addr: 32'h0000_0300, wr: 1'b0, size: 3'd2, wdata: 32'h0});
    @(posedge clk); #1;
    m_hsel[0] = 1'b0; m_htrans[0] = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dphase) found = 1'b1;
    end
    chk("rst_wait_seen", 64'(found), 64'(1));
    #1;
    rst = 1'b1;
    m_exp0.delete(); m_exp1.delete(); s_exp.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check_reset("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    ws = 1;
    s_exp.push_back('{addr: 32'h0000_0400, wr: 1'b0, size: 3'd2, wdata: 32'h0});
    master_seq(1, 1, 32'h0000_0400, 1'b0, 3'd2, 32'h0);
    @(posedge clk); #1;

    chk("final_s_exp", 64'(s_exp.size()), 64'(0));
    chk("final_m_exp0", 64'(m_exp0.size()), 64'(0));
    chk("final_m_exp1", 64'(m_exp1.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
